// File: rtl/biriscv_csr_hpm.sv
// biriscv_csr_hpm: mcycle/minstret, programmable hpm counters, inhibit/enable control and overflow interrupt
module biriscv_csr_hpm #(
    parameter int NUM_HPM    = 4,
    parameter int NUM_EVENTS = 8,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic [1:0]            retire_cnt_i,
    input  logic [1:0]            priv_i,
    input  logic                  csr_ren_i,
    input  logic [11:0]           csr_raddr_i,
    output logic [31:0]           csr_rdata_o,
    output logic                  csr_hit_o,
    output logic                  csr_fault_o,
    input  logic [11:0]           csr_waddr_i,
    input  logic [31:0]           csr_wdata_i,
    output logic                  ovf_irq_o
);
    localparam int NC = NUM_HPM + 3;
    // Counter indices that exist: 0 (cycle), 2 (instret), 3.. (hpm); index 1 (time) lives elsewhere
    localparam logic [31:0] MASK = 32'((64'd1 << NC) - 64'd1) & ~32'h2;

    logic [CNT_W-1:0] cnt [NC];
    logic [CNT_W-1:0] nxt [NC];
    logic [4:0]       sel [NUM_HPM];
    logic [NUM_HPM-1:0] of, hpm_hit, wrap, wev;
    logic [NC-1:0]    inhibit, counteren, wlo, whi, step1;
    logic [31:0]      ev_vec, ev_rd, ce;
    logic [63:0]      cv;
    logic [4:0]       ridx;
    logic             is_c, is_cnt, is_ev;

    always_comb begin
        ev_vec = 32'({event_i, 1'b0});
        for (int k = 0; k < NUM_HPM; k++) begin
            hpm_hit[k] = ev_vec[sel[k]];
            wev[k] = csr_waddr_i == 12'h323 + 12'(k);
        end
        step1 = {hpm_hit, 3'b001};
        for (int i = 0; i < NC; i++) begin
            wlo[i] = MASK[i] && csr_waddr_i == 12'hB00 + 12'(i);
            whi[i] = MASK[i] && csr_waddr_i == 12'hB80 + 12'(i);
            nxt[i] = inhibit[i] ? cnt[i] : cnt[i] + CNT_W'(i == 2 ? retire_cnt_i : {1'b0, step1[i]});
        end
        for (int k = 0; k < NUM_HPM; k++)
            wrap[k] = hpm_hit[k] && !inhibit[k+3] && &cnt[k+3] && !wlo[k+3] && !whi[k+3];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NC; i++) cnt[i] <= '0;
            for (int k = 0; k < NUM_HPM; k++) sel[k] <= '0;
            of        <= '0;
            inhibit   <= '0;
            counteren <= '0;
            ovf_irq_o <= 1'b0;
        end else begin
            for (int i = 0; i < NC; i++)
                cnt[i] <= wlo[i] ? {cnt[i][CNT_W-1:32], csr_wdata_i} :
                          whi[i] ? {csr_wdata_i[CNT_W-33:0], cnt[i][31:0]} : nxt[i];
            for (int k = 0; k < NUM_HPM; k++) begin
                if (wev[k]) begin
                    sel[k] <= csr_wdata_i[4:0];
                    of[k]  <= csr_wdata_i[31];
                end else if (wrap[k]) begin
                    of[k] <= 1'b1;
                end
            end
            if (csr_waddr_i == 12'h320) inhibit <= csr_wdata_i[NC-1:0] & MASK[NC-1:0];
            if (csr_waddr_i == 12'h306) counteren <= csr_wdata_i[NC-1:0] & MASK[NC-1:0];
            ovf_irq_o <= |of;
        end
    end

    always_comb begin
        ridx  = csr_raddr_i[4:0];
        cv    = '0;
        ev_rd = '0;
        for (int i = 0; i < NC; i++)
            if (5'(i) == ridx) cv = 64'(cnt[i]);
        for (int k = 0; k < NUM_HPM; k++)
            if (5'(k + 3) == ridx) ev_rd = {of[k], 26'b0, sel[k]};
        is_c   = csr_raddr_i[11:8] == 4'hC;
        is_cnt = (is_c || csr_raddr_i[11:8] == 4'hB) && csr_raddr_i[6:5] == 2'b00 && MASK[ridx];
        is_ev  = csr_raddr_i[11:5] == 7'h19 && ridx >= 5'd3 && MASK[ridx];
        ce     = 32'(counteren);
        csr_hit_o   = is_cnt || is_ev || csr_raddr_i == 12'h320 || csr_raddr_i == 12'h306;
        csr_fault_o = csr_ren_i && priv_i != 2'd3 && is_c && is_cnt && !ce[ridx];
        csr_rdata_o = (!csr_ren_i || csr_fault_o) ? '0 :
                      is_cnt ? (csr_raddr_i[7] ? cv[63:32] : cv[31:0]) :
                      is_ev ? ev_rd :
                      csr_raddr_i == 12'h320 ? 32'(inhibit) :
                      csr_raddr_i == 12'h306 ? ce : '0;
    end
endmodule

// File: tb/tb_biriscv_csr_hpm.sv
// tb_biriscv_csr_hpm: randomized and directed checks of the HPM CSR block against a behavioural model
module tb_biriscv_csr_hpm;
    localparam int NH = 4;
    localparam int NE = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ev = '0;
    logic [1:0]  ret = '0, priv = 2'd3;
    logic        ren = 1'b1;
    logic [11:0] raddr = '0, waddr = '0;
    logic [31:0] wdata = '0, rdata;
    logic        hit, fault, irq;
    int checks = 0, errors = 0;

    always #50 clk = ~clk;

    biriscv_csr_hpm #(.NUM_HPM(NH), .NUM_EVENTS(NE), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .event_i(ev), .retire_cnt_i(ret), .priv_i(priv),
        .csr_ren_i(ren), .csr_raddr_i(raddr), .csr_rdata_o(rdata), .csr_hit_o(hit),
        .csr_fault_o(fault), .csr_waddr_i(waddr), .csr_wdata_i(wdata), .ovf_irq_o(irq)
    );

    longint unsigned mc [32];
    logic [4:0]      msel [32];
    bit              mof [32];
    logic [31:0]     minh = '0, men = '0;
    bit              mirq = 1'b0;

    function automatic bit owned(int n);
        return n == 0 || n == 2 || (n >= 3 && n < 3 + NH);
    endfunction

    function automatic logic [31:0] wmask();
        logic [31:0] m = 32'h5;
        for (int k = 3; k < 3 + NH; k++) m[k] = 1'b1;
        return m;
    endfunction

    function automatic void exp_read(input logic [11:0] a, input logic [1:0] p, input logic r,
                                     output logic [31:0] d, output logic h, output logic f);
        int n = int'(a[4:0]);
        logic [31:0] v = '0;
        h = 1'b0;
        f = 1'b0;
        if (a == 12'h320) begin h = 1'b1; v = minh; end
        else if (a == 12'h306) begin h = 1'b1; v = men; end
        else if (a >= 12'h323 && a < 12'h323 + NH) begin h = 1'b1; v = {mof[n], 26'b0, msel[n]}; end
        else if ((a[11:8] == 4'hB || a[11:8] == 4'hC) &&
                 (a[7:0] < 8'h20 || (a[7:0] >= 8'h80 && a[7:0] < 8'hA0)) && owned(n)) begin
            h = 1'b1;
            v = a[7] ? mc[n][63:32] : mc[n][31:0];
            f = a[11:8] == 4'hC && p != 2'd3 && !men[n];
        end
        f = f && r;
        d = (r && h && !f) ? v : 32'h0;
    endfunction

    // Applies one clock edge of architectural rules to the model, then advances the DUT
    task automatic step();
        bit any_of;
        bit [31:0] wrapped;
        logic [4:0] s;
        any_of = 1'b0;
        wrapped = '0;
        for (int n = 3; n < 3 + NH; n++) any_of |= mof[n];
        if (rst) begin
            for (int n = 0; n < 32; n++) begin mc[n] = 0; msel[n] = '0; mof[n] = 1'b0; end
            minh = '0; men = '0; mirq = 1'b0;
        end else begin
            for (int n = 0; n < 32; n++) if (owned(n)) begin
                s = msel[n];
                if (waddr == 12'hB00 + 12'(n)) mc[n][31:0] = wdata;
                else if (waddr == 12'hB80 + 12'(n)) mc[n][63:32] = wdata;
                else if (!minh[n]) begin
                    if (n == 0) mc[n]++;
                    else if (n == 2) mc[n] += 64'(ret);
                    else if (s >= 5'd1 && s <= 5'(NE) && ev[s-5'd1]) begin
                        wrapped[n] = mc[n] == 64'hFFFF_FFFF_FFFF_FFFF;
                        mc[n]++;
                    end
                end
            end
            for (int n = 3; n < 3 + NH; n++) begin
                if (waddr == 12'h320 + 12'(n)) begin msel[n] = wdata[4:0]; mof[n] = wdata[31]; end
                else if (wrapped[n]) mof[n] = 1'b1;
            end
            if (waddr == 12'h320) minh = wdata & wmask();
            if (waddr == 12'h306) men = wdata & wmask();
            mirq = any_of;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        waddr = a; wdata = d;
        step();
        waddr = '0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic h, output logic f);
        raddr = a;
        #1;
        d = rdata; h = hit; f = fault;
    endtask

    task automatic test_reset();
        logic [31:0] d, ed;
        logic h, f, eh, ef;
        logic [11:0] al [8] = '{12'hB00, 12'hB02, 12'hB03, 12'hB06, 12'hB83, 12'h323, 12'h320, 12'h306};
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        foreach (al[i]) begin
            rd(al[i], d, h, f);
            exp_read(al[i], priv, ren, ed, eh, ef);
            checks++;
            if (d !== 32'h0 || d !== ed || h !== eh || f !== ef) begin
                errors++;
                $display("FAIL reset_read a=%h got d=%h h=%b f=%b want d=%h h=%b f=%b", al[i], d, h, f, ed, eh, ef);
            end
        end
        repeat (10) step();
        rd(12'hB00, d, h, f);
        checks++;
        if (d !== 32'd10) begin errors++; $display("FAIL idle_mcycle got %0d want 10", d); end
        rd(12'hB02, d, h, f);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL idle_minstret got %0d want 0", d); end
    endtask

    task automatic test_minstret();
        logic [31:0] d;
        logic h, f;
        ret = 2'd2; repeat (5) step();
        ret = 2'd1; repeat (3) step();
        ret = 2'd0;
        rd(12'hB02, d, h, f);
        checks++;
        if (d !== 32'd13) begin errors++; $display("FAIL minstret got %0d want 13", d); end
        wr(12'h320, 32'h4);
        ret = 2'd1; repeat (4) step();
        ret = 2'd0;
        rd(12'hB02, d, h, f);
        checks++;
        if (d !== 32'd13) begin errors++; $display("FAIL minstret_inhibit got %0d want 13", d); end
        rd(12'h320, d, h, f);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL inhibit_read got %h want 4", d); end
        wr(12'h320, 32'hFFFF_FFFF);
        rd(12'h320, d, h, f);
        checks++;
        if (d !== wmask()) begin errors++; $display("FAIL inhibit_mask got %h want %h", d, wmask()); end
        wr(12'h320, 32'h0);
    endtask

    task automatic test_hpm();
        logic [31:0] d;
        logic h, f;
        logic [11:0] pat = 12'b1011_0101_1010;
        wr(12'h323, 32'd2);
        for (int i = 0; i < 12; i++) begin
            ev = {6'b0, pat[i], i[0]};
            step();
        end
        ev = '0;
        rd(12'hB03, d, h, f);
        checks++;
        if (d !== 32'd7) begin errors++; $display("FAIL hpm_count got %0d want 7", d); end
        wr(12'h323, 32'(NE + 1));
        repeat (6) begin ev = 8'($urandom); step(); end
        ev = '0;
        rd(12'hB03, d, h, f);
        checks++;
        if (d !== 32'd7) begin errors++; $display("FAIL hpm_badsel got %0d want 7", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d, d2, e;
        logic h, f;
        ev = '0;
        wr(12'hB03, 32'hFFFF_FFFE);
        wr(12'hB83, 32'hFFFF_FFFF);
        wr(12'h323, 32'd1);
        ev = 8'h1;
        step();
        rd(12'hB03, d, h, f); rd(12'hB83, d2, h, f);
        checks++;
        if (d !== 32'hFFFF_FFFF || d2 !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL ovf_allones got %h_%h want ffffffff_ffffffff", d2, d);
        end
        step();
        rd(12'hB03, d, h, f); rd(12'hB83, d2, h, f); rd(12'h323, e, h, f);
        checks++;
        if (d !== 0 || d2 !== 0 || e !== 32'h8000_0001 || irq !== 1'b0) begin
            errors++; $display("FAIL ovf_wrap got cnt=%h_%h ev=%h irq=%b want 0_0 80000001 0", d2, d, e, irq);
        end
        step();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL ovf_irq_rise got %b want 1", irq); end
        wr(12'h323, 32'd1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL ovf_irq_hold got %b want 1", irq); end
        step();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL ovf_irq_fall got %b want 0", irq); end
        ev = '0;
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'hB83, 32'hFFFF_FFFF);
        ev = 8'h1; waddr = 12'h323; wdata = 32'd1;
        step();
        waddr = '0;
        rd(12'hB03, d, h, f); rd(12'h323, e, h, f);
        checks++;
        if (d !== 0 || e !== 32'd1) begin
            errors++; $display("FAIL ovf_write_wins got cnt=%h ev=%h want 0 00000001", d, e);
        end
        ev = '0;
        step();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL ovf_write_irq got %b want 0", irq); end
    endtask

    task automatic test_fault();
        logic [31:0] d, ed;
        logic h, f, eh, ef;
        priv = 2'd0;
        rd(12'hC00, d, h, f);
        checks++;
        if (f !== 1'b1 || d !== 0 || h !== 1'b1) begin
            errors++; $display("FAIL fault_denied got f=%b d=%h h=%b want 1 0 1", f, d, h);
        end
        wr(12'h306, 32'h1);
        rd(12'hC00, d, h, f);
        exp_read(12'hC00, priv, ren, ed, eh, ef);
        checks++;
        if (f !== 1'b0 || d !== ed || d !== mc[0][31:0]) begin
            errors++; $display("FAIL fault_allowed got f=%b d=%h want 0 %h", f, d, ed);
        end
        rd(12'hC01, d, h, f);
        checks++;
        if (h !== 1'b0 || d !== 0 || f !== 1'b0) begin
            errors++; $display("FAIL time_unowned got h=%b d=%h f=%b want 0 0 0", h, d, f);
        end
        rd(12'hC02, d, h, f);
        checks++;
        if (f !== 1'b1 || d !== 0) begin errors++; $display("FAIL fault_instret got f=%b d=%h want 1 0", f, d); end
        priv = 2'd3;
        rd(12'hC02, d, h, f);
        exp_read(12'hC02, priv, ren, ed, eh, ef);
        checks++;
        if (f !== 1'b0 || d !== ed) begin errors++; $display("FAIL machine_read got f=%b d=%h want 0 %h", f, d, ed); end
        ren = 1'b0;
        rd(12'hB00, d, h, f);
        checks++;
        if (d !== 0 || f !== 1'b0 || h !== 1'b1) begin
            errors++; $display("FAIL no_ren got d=%h f=%b h=%b want 0 0 1", d, f, h);
        end
        ren = 1'b1;
    endtask

    task automatic test_write();
        logic [31:0] d, ed;
        logic h, f, eh, ef;
        waddr = 12'hB00; wdata = 32'd5;
        rd(12'hB00, d, h, f);
        exp_read(12'hB00, priv, ren, ed, eh, ef);
        checks++;
        if (d !== ed) begin errors++; $display("FAIL read_old got %h want %h", d, ed); end
        step();
        waddr = '0;
        rd(12'hB00, d, h, f);
        checks++;
        if (d !== 32'd5) begin errors++; $display("FAIL mcycle_write got %0d want 5", d); end
        rd(12'hB80, d, h, f);
        exp_read(12'hB80, priv, ren, ed, eh, ef);
        checks++;
        if (d !== ed) begin errors++; $display("FAIL mcycle_hi_kept got %h want %h", d, ed); end
        step();
        rd(12'hB00, d, h, f);
        checks++;
        if (d !== 32'd6) begin errors++; $display("FAIL mcycle_next got %0d want 6", d); end
        wr(12'hB82, 32'h1234);
        rd(12'hB02, d, h, f);
        checks++;
        if (d !== 32'd13) begin errors++; $display("FAIL hi_write_keeps_lo got %0d want 13", d); end
        rd(12'hC82, d, h, f);
        checks++;
        if (d !== 32'h1234) begin errors++; $display("FAIL hi_write got %h want 1234", d); end
    endtask

    task automatic test_random();
        logic [31:0] d, ed;
        logic h, f, eh, ef;
        logic [11:0] wl [20] = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06, 12'hB83, 12'hB86,
                                 12'h323, 12'h324, 12'h325, 12'h326, 12'h320, 12'h306, 12'hC00, 12'hC03,
                                 12'hB01, 12'hB07, 12'h000, 12'h327};
        logic [11:0] a;
        for (int c = 0; c < 400; c++) begin
            ev = 8'($urandom);
            ret = 2'($urandom_range(0, 2));
            priv = 2'($urandom);
            ren = $urandom_range(0, 7) != 0;
            waddr = '0;
            if ($urandom_range(0, 3) == 0) begin
                waddr = wl[$urandom_range(0, 19)];
                wdata = $urandom;
                if (waddr[11:8] == 4'h3 && waddr != 12'h306) wdata[4:0] = 5'($urandom_range(0, 10));
                if (waddr == 12'h320) wdata = wdata & $urandom & $urandom;
                if (waddr[11:8] == 4'hB && $urandom_range(0, 1) == 1) wdata = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            end
            for (int r = 0; r < 2; r++) begin
                a = $urandom_range(0, 1) == 1 ? wl[$urandom_range(0, 19)] : 12'($urandom);
                if (r == 1) a = {4'hC, 1'($urandom), 2'b00, 5'($urandom_range(0, 8))};
                rd(a, d, h, f);
                exp_read(a, priv, ren, ed, eh, ef);
                checks++;
                if (d !== ed || h !== eh || f !== ef) begin
                    errors++;
                    $display("FAIL random_read c=%0d a=%h got d=%h h=%b f=%b want d=%h h=%b f=%b", c, a, d, h, f, ed, eh, ef);
                end
            end
            checks++;
            if (irq !== mirq) begin errors++; $display("FAIL random_irq c=%0d got %b want %b", c, irq, mirq); end
            step();
        end
        waddr = '0; ev = '0; ret = '0; priv = 2'd3; ren = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic h, f;
        logic [11:0] al [6] = '{12'hB00, 12'hB02, 12'hB03, 12'h323, 12'h320, 12'h306};
        wr(12'h323, 32'h8000_0002);
        step();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b want 1", irq); end
        ev = 8'hFF; ret = 2'd2; waddr = 12'hB00; wdata = 32'h77;
        rst = 1'b1;
        step();
        rst = 1'b0; ev = '0; ret = '0; waddr = '0;
        foreach (al[i]) begin
            rd(al[i], d, h, f);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL mid_reset a=%h got %h want 0", al[i], d); end
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq got %b want 0", irq); end
    endtask

    initial begin
        test_reset();
        test_minstret();
        test_hpm();
        test_overflow();
        test_fault();
        test_write();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/biriscv_csr_hpm.md
# biriscv_csr_hpm

Hardware performance monitor CSR block for the biRISC-V core: implements mcycle, minstret and NUM_HPM programmable mhpmcounters with event selectors, counter inhibit, counter-enable access control and sticky overflow flags with an overflow interrupt. It sits beside the CSR register file. It serves counter CSR reads at issue (same address and read-enable as the register file read port). It takes counter CSR writes from the writeback CSR port, and counts per-cycle event and retire pulses from the pipeline.

## Interface
- NUM_HPM, 4, number of programmable counters mhpmcounter3..(3+NUM_HPM-1); legal 1..29
- NUM_EVENTS, 8, width of event_i; legal 1..31
- CNT_W, 64, implemented counter width; legal 33..64
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- event_i  in  NUM_EVENTS  per-cycle event pulses; bit e counts as event code e+1
- retire_cnt_i  in  2  instructions retired this cycle (0..2, dual issue)
- priv_i  in  2  current privilege (3 = machine)
- csr_ren_i  in  1  read enable at issue
- csr_raddr_i  in  12  read address
- csr_rdata_o  out  32  read data; 0 when !csr_ren_i or no hit
- csr_hit_o  out  1  csr_raddr_i decodes to a CSR owned by this block
- csr_fault_o  out  1  lower-privilege counter read denied by mcounteren
- csr_waddr_i  in  12  write address; 12'h000 = no write
- csr_wdata_i  in  32  write data
- ovf_irq_o  out  1  registered OR of all overflow flags

## Operation
- Owned CSRs:
  - mcountinhibit 0x320
  - mcounteren 0x306
  - mhpmevent 0x323+k
  - mcycle/minstret 0xB00/0xB02, mhpmcounter 0xB03+k
  - high halves 0xB80/0xB82/0xB83+k
  - user read-only shadows 0xC00/0xC02/0xC03+k, high halves 0xC80/0xC82/0xC83+k
  - k = 0..NUM_HPM-1
- 0xC01/0xC81 (time) and counter indices ≥3+NUM_HPM are not owned: hit=0, rdata=0, writes ignored.
- Read/write registers:
  - mcountinhibit: bits 0, 2, 3..2+NUM_HPM writable; all other bits, including bit 1, read 0.
  - mcounteren: same writable mask as mcountinhibit.
- mhpmevent fields:
  - [4:0] event select
  - [31] OF, sticky overflow flag
  - all other bits read 0
- Increment rules, per cycle, when the counter's inhibit bit is 0:
  - mcycle +1
  - minstret +retire_cnt_i
  - hpm k +1 when sel in 1..NUM_EVENTS and event_i[sel-1]=1
  - sel=0 or sel>NUM_EVENTS counts nothing
- Width: counters are CNT_W bits and wrap from 2^CNT_W−1 to 0.
  - Low half reads bits [31:0].
  - High half reads bits [CNT_W−1:32], zero-extended.
  - Write to the high half loads only the implemented bits.
- Overflow:
  - An hpm counter wrapping to 0 by increment sets its OF.
  - minstret adding 2 at all-ones−1 wraps to 0 with no OF.
  - mcycle/minstret have no OF.
- Writes via csr_waddr_i:
  - Write to a low/high half replaces that half and keeps the other half.
  - A write suppresses that counter's increment in the same cycle; the write wins.
  - mhpmevent write replaces sel and OF. Writing OF=1 sets it; writing 0 clears it. The write wins over a same-cycle overflow.
  - Writes to 0xCxx are ignored; read-only faults are raised upstream.
- Access fault: csr_fault_o=1 when all of the following hold:
  - csr_ren_i=1 and priv_i≠3
  - address in 0xC00–0xC1F or 0xC80–0xC9F, owned
  - mcounteren[addr[4:0]]=0
  - When faulting, csr_rdata_o=0.
- Machine-level reads never fault.

## Timing
- Reset (rst high at a clk edge):
  - all counters, mcountinhibit, mcounteren and mhpmevent are 0
  - ovf_irq_o=0
  - csr_rdata_o/csr_hit_o/csr_fault_o follow the combinational decode of the reset state
- Reset asserted mid-count takes effect at that edge; no increment is applied in the reset cycle.
- Reads are combinational, same cycle as csr_ren_i, and return the pre-edge value.
- A read in the same cycle as a write to the same CSR returns the old value. The new value is visible the next cycle.
- Counters update at every edge; a read in cycle N sees all increments through edge N−1.
- OF is set at the wrap edge; ovf_irq_o rises one cycle later and stays high until every OF is cleared. Fall latency is also one cycle.
- Inhibit takes effect from the edge after the mcountinhibit write; the write-cycle increment still applies.

## Test plan
- Reset, then idle 10 cycles → mcycle reads 10, minstret 0, all hpm 0, ovf_irq_o=0.
- retire_cnt_i=2 for 5 cycles then 1 for 3 cycles → minstret=13. Set mcountinhibit[2]=1, then retire 4 cycles → minstret unchanged.
- mhpmevent3 sel=2, pulse event_i[1] on 7 of 12 cycles, with event_i[0] toggling → mhpmcounter3=7. Set sel=NUM_EVENTS+1 → no further counting.
- Load mhpmcounter3 to 2^CNT_W−2 (low then high write), sel=1, event_i[0] held high:
  - value becomes all-ones, then 0
  - OF=1 at the wrap edge; ovf_irq_o=1 one cycle later
  - writing mhpmevent3 with bit31=0 → ovf_irq_o=0 one cycle later
  - same-cycle wrap and OF=0 write → OF stays 0
- priv_i=0, mcounteren=0, read 0xC00 → fault=1, rdata=0. Set mcounteren[0]=1 → fault=0, rdata=mcycle low. Read 0xC01 → hit=0.
- Write mcycle low=0x0000_0005 while counting → reads 5 next cycle, 6 after that. Assert rst mid-count → all reads 0 next cycle.
